regbank_write_arbiter: RTL

Shares the single write port of the 8-entry × 8-bit register bank (an array of reg8bits instances) between several requesters, e.g. writeback, load unit and debug.
- Arbitrates round-robin and supports locked multi-beat bursts.
- Decodes the winning address into the per-register EN one-hot and drives the shared D bus.
- Sits between the pipeline write sources and the register bank.

---
 rtl/regbank_write_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the shared write port of the register bank, with locked bursts.
// Latency: an accepted beat appears on reg_en/reg_d/grant_id exactly one cycle later.
// Backpressure: req_ready is combinational; the losers of arbitration and all non-owners during a lock wait.
//
// Ports: clk/rst (async, active-low); req_valid/req_last/req_addr/req_data from NREQ requesters,
// req_ready back to them; reg_en (one-hot) and reg_d to the bank; grant_id, busy, timeout_err status.
// Optional feature macro: LOCK_TIMEOUT_EN (forced lock release after LOCK_MAX idle lock cycles).
module regbank_write_arbiter #(
    parameter int NREQ         = 4,
    parameter int NREG         = 8,
    parameter int W            = 8,
    parameter int ZERO_PROTECT = 1,
    parameter int LOCK_MAX     = 16,
    localparam int AW          = $clog2(NREG),
    localparam int IW          = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_last,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*W-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREG-1:0]     reg_en,
    output logic [W-1:0]        reg_d,
    output logic [IW-1:0]       grant_id,
    output logic                busy,
    output logic                timeout_err
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;

    logic [IW-1:0]   winner;
    logic            win_vld;
    logic [IW-1:0]   sel;
    logic            acc;
    logic            sel_last;
    logic [AW-1:0]   sel_addr;
    logic [W-1:0]    sel_data;
    logic [IW-1:0]   next_ptr;
    logic [NREG-1:0] dec;
    logic            force_rel;

    // Scan from the highest offset down so the first valid requester at or after ptr wins.
    always_comb begin
        winner  = '0;
        win_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                winner  = IW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE) begin
            if (win_vld) req_ready[winner] = 1'b1;
        end else if (!force_rel) begin
            req_ready[owner] = req_valid[owner];
        end
    end

    assign sel      = (state == IDLE) ? winner : owner;
    assign acc      = |(req_ready & req_valid);
    assign sel_last = req_last[sel];
    assign sel_addr = req_addr[sel*AW +: AW];
    assign sel_data = req_data[sel*W +: W];
    assign next_ptr = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);

    always_comb begin
        dec           = '0;
        dec[sel_addr] = 1'b1;
        if (ZERO_PROTECT != 0 && sel_addr == '0) dec = '0;
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] lock_cnt;

    // Release fires in the idle lock cycle that brings the count up to LOCK_MAX.
    assign force_rel = (state == LOCK) && !req_valid[owner] && (lock_cnt == CW'(LOCK_MAX - 1));
`else
    assign force_rel   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            reg_en   <= '0;
            reg_d    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
            lock_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            reg_en <= '0;
`ifdef LOCK_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            if (acc) begin
                reg_en   <= dec;
                reg_d    <= sel_data;
                grant_id <= sel;
            end
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (sel_last) begin
                            ptr <= next_ptr;
                        end else begin
                            state <= LOCK;
                            owner <= sel;
                            busy  <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (acc) begin
`ifdef LOCK_TIMEOUT_EN
                        lock_cnt <= '0;
`endif
                        if (sel_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            ptr   <= next_ptr;
                        end
                    end else begin
`ifdef LOCK_TIMEOUT_EN
                        if (force_rel) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            ptr         <= next_ptr;
                            lock_cnt    <= '0;
                            timeout_err <= 1'b1;
                        end else begin
                            lock_cnt <= lock_cnt + CW'(1);
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
